// File: rtl/draw_square_grid.sv
// rtl/draw_square_grid.sv - board grid overlay: two-stage pixel pipeline painting cell marks and a blinking cursor.
// Pending board takes writes at any time; the displayed board and cursor latch only move on a vsync rising edge.
module draw_square_grid #(
  parameter int          ROWS         = 3,
  parameter int          COLS         = 3,
  parameter int          X0           = 0,
  parameter int          Y0           = 0,
  parameter int          CELL_W       = 341,
  parameter int          CELL_H       = 256,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] CURSOR_COLOR = 12'hfff,
  localparam int         N            = ROWS * COLS,
  localparam int         IW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [10:0]   hcount_in,
  input  logic [10:0]   vcount_in,
  input  logic          hsync_in,
  input  logic          hblnk_in,
  input  logic          vsync_in,
  input  logic          vblnk_in,
  input  logic [11:0]   rgb_in,
  input  logic          start_en,
  input  logic          choice_en,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [1:0]    wr_val,
  input  logic          clr,
  input  logic          cursor_en,
  input  logic [IW-1:0] cursor_idx,
  output logic [10:0]   hcount_out,
  output logic [10:0]   vcount_out,
  output logic          hsync_out,
  output logic          hblnk_out,
  output logic          vsync_out,
  output logic          vblnk_out,
  output logic [11:0]   rgb_out,
  output logic          busy
);

  localparam int          FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [11:0] X_LO   = 12'(X0);
  localparam logic [11:0] Y_LO   = 12'(Y0);
  localparam logic [11:0] X_SPAN = 12'(COLS * CELL_W - 1);
  localparam logic [11:0] Y_SPAN = 12'(ROWS * CELL_H - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [10:0]   hcount1_q, vcount1_q;
  logic [3:0]    sync1_q;
  logic [11:0]   rgb1_q;
  logic          en1_q, hit1_q;
  logic [IW-1:0] idx1_q;
  logic [2*N-1:0] pend_q, pend_d, disp_q;
  logic [IW-1:0] cur_q;
  logic [FW-1:0] frame_q;
  logic          blink_q, vs_prev_q;

  // 13-bit subtraction: the top bit flags a position left of / above the grid
  logic [12:0] dx_c, dy_c;
  logic        hit_c, vs_rise_c;
  int          col_c, row_c;
  logic [IW-1:0] idx_c;

  assign dx_c      = {2'b00, hcount_in} - {1'b0, X_LO};
  assign dy_c      = {2'b00, vcount_in} - {1'b0, Y_LO};
  assign hit_c     = !dx_c[12] && !dy_c[12] && (dx_c[11:0] <= X_SPAN) && (dy_c[11:0] <= Y_SPAN);
  assign vs_rise_c = vsync_in && !vs_prev_q;

  always_comb begin
    col_c = 0;
    row_c = 0;
    for (int c = 1; c < COLS; c++)
      if (dx_c[11:0] >= 12'(c * CELL_W)) col_c = c;
    for (int r = 1; r < ROWS; r++)
      if (dy_c[11:0] >= 12'(r * CELL_H)) row_c = r;
    idx_c = IW'(row_c * COLS + col_c);
  end

  always_comb begin
    pend_d = pend_q;
    if (clr)
      pend_d = '0;
    else if (wr_en && (int'(wr_idx) < N) && (wr_val != 2'd3))
      pend_d[{wr_idx, 1'b0} +: 2] = wr_val;
  end

  logic [1:0]  mark_c;
  logic        cursor_c;
  logic [11:0] rgb_c;

  always_comb begin
    mark_c   = disp_q[{idx1_q, 1'b0} +: 2];
    cursor_c = cursor_en && (int'(cur_q) < N) && (idx1_q == cur_q) && blink_q;
    rgb_c    = rgb1_q;
    if (en1_q && hit1_q) begin
      if (cursor_c)            rgb_c = CURSOR_COLOR;
      else if (mark_c == 2'd1) rgb_c = 12'h00f;
      else if (mark_c == 2'd2) rgb_c = 12'hff0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount1_q <= '0; vcount1_q <= '0; sync1_q <= '0; rgb1_q <= '0;
      en1_q <= 1'b0; hit1_q <= 1'b0; idx1_q <= '0;
      hcount_out <= '0; vcount_out <= '0; rgb_out <= '0;
      hsync_out <= 1'b0; hblnk_out <= 1'b0; vsync_out <= 1'b0; vblnk_out <= 1'b0;
      pend_q <= '0; disp_q <= '0; cur_q <= '0; busy <= 1'b0;
      frame_q <= '0; blink_q <= 1'b1; vs_prev_q <= 1'b0;
    end else begin
      hcount1_q <= hcount_in;
      vcount1_q <= vcount_in;
      sync1_q   <= {hsync_in, hblnk_in, vsync_in, vblnk_in};
      rgb1_q    <= rgb_in;
      en1_q     <= start_en && !choice_en;
      hit1_q    <= hit_c;
      idx1_q    <= idx_c;

      hcount_out <= hcount1_q;
      vcount_out <= vcount1_q;
      {hsync_out, hblnk_out, vsync_out, vblnk_out} <= sync1_q;
      rgb_out    <= rgb_c;

      vs_prev_q <= vsync_in;
      pend_q    <= pend_d;
      busy      <= (pend_q != disp_q);
      if (vs_rise_c) begin
        disp_q <= pend_q;
        cur_q  <= cursor_idx;
      end

      // Holding the blink at "on" while disabled makes a re-enabled cursor appear at once
      if (!cursor_en) begin
        frame_q <= '0;
        blink_q <= 1'b1;
      end else if (vs_rise_c) begin
        if (frame_q == F_LAST) begin
          frame_q <= '0;
          blink_q <= !blink_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_square_grid.sv
// tb/tb_draw_square_grid.sv - directed self-checking bench for draw_square_grid.
module tb_draw_square_grid;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        start_en, choice_en, wr_en, clr, cursor_en;
  logic [3:0]  wr_idx, cursor_idx;
  logic [1:0]  wr_val;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  draw_square_grid #(.BLINK_FRAMES(2)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val), .clr(clr),
    .cursor_en(cursor_en), .cursor_idx(cursor_idx),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .busy(busy)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [11:0] rgb,
                     input logic [11:0] exp);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = rgb;
    tick();
    tick();
    chk(tag, 32'(rgb_out), 32'(exp));
  endtask

  task automatic wr(input int idx, input int val, input logic c);
    wr_en  = 1'b1;
    wr_idx = 4'(idx);
    wr_val = 2'(val);
    clr    = c;
    tick();
    wr_en  = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    hcount_in = 11'd100; vcount_in = 11'd50; rgb_in = 12'h5a5;
    hsync_in = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
    start_en = 1'b1; choice_en = 1'b0; wr_en = 1'b0; clr = 1'b0;
    wr_idx = '0; wr_val = '0; cursor_en = 1'b0; cursor_idx = '0;
    tick(); tick();
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    chk("rst_hcount", 32'(hcount_out), 32'd0);
    chk("rst_hsync", 32'(hsync_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    hsync_in = 1'b0;
    rst_n = 1'b1;
    pix("first_pass", 20, 20, 12'h321, 12'h321);

    // passthrough with drawing disabled
    start_en = 1'b0;
    hsync_in = 1'b1;
    pix("pass_rgb", 700, 600, 12'h123, 12'h123);
    chk("pass_hcount", 32'(hcount_out), 32'd700);
    chk("pass_vcount", 32'(vcount_out), 32'd600);
    chk("pass_hsync", 32'(hsync_out), 32'd1);
    hsync_in = 1'b0;
    start_en = 1'b1;

    // mark cell 8
    wr(8, 1, 1'b0);
    tick();
    chk("mark_busy1", 32'(busy), 32'd1);
    vs_pulse();
    chk("mark_busy0", 32'(busy), 32'd0);
    pix("mark_lo", 685, 512, 12'h222, 12'h00f);
    pix("mark_hi", 1022, 767, 12'h222, 12'h00f);
    pix("mark_left", 681, 600, 12'h333, 12'h333);
    pix("mark_xout", 1023, 600, 12'h444, 12'h444);
    pix("mark_yout", 685, 768, 12'h555, 12'h555);
    choice_en = 1'b1;
    pix("mark_choice", 685, 600, 12'h666, 12'h666);
    choice_en = 1'b0;

    // tearing: write mid-frame, visible only after next vsync
    vcount_in = 11'd400;
    wr(4, 2, 1'b0);
    pix("tear_same", 500, 400, 12'h777, 12'h777);
    vs_pulse();
    pix("tear_next", 500, 400, 12'h777, 12'hff0);
    pix("tear_keep8", 700, 600, 12'h777, 12'h00f);

    // illegal writes are dropped
    wr(9, 1, 1'b0);
    wr(0, 3, 1'b0);
    tick();
    chk("illegal_busy", 32'(busy), 32'd0);
    vs_pulse();
    pix("illegal_c0", 20, 20, 12'h888, 12'h888);
    pix("illegal_c8", 700, 600, 12'h888, 12'h00f);

    // clr beats wr_en
    wr(0, 1, 1'b1);
    tick();
    chk("clr_busy", 32'(busy), 32'd1);
    vs_pulse();
    pix("clr_c0", 20, 20, 12'h999, 12'h999);
    pix("clr_c4", 500, 400, 12'h999, 12'h999);
    pix("clr_c8", 700, 600, 12'h999, 12'h999);

    // blink: 2 frames on, 2 frames off
    wr(0, 1, 1'b0);
    cursor_idx = 4'd0;
    vs_pulse();
    cursor_en = 1'b1;
    pix("blink_f0", 20, 20, 12'h111, 12'hfff);
    vs_pulse();
    pix("blink_f1", 20, 20, 12'h111, 12'hfff);
    vs_pulse();
    pix("blink_f2", 20, 20, 12'h111, 12'h00f);
    vs_pulse();
    pix("blink_f3", 20, 20, 12'h111, 12'h00f);
    vs_pulse();
    pix("blink_f4", 20, 20, 12'h111, 12'hfff);
    vs_pulse();
    pix("blink_f5", 20, 20, 12'h111, 12'hfff);
    vs_pulse();
    pix("blink_f6", 20, 20, 12'h111, 12'h00f);
    pix("blink_other", 500, 400, 12'h111, 12'h111);
    cursor_en = 1'b0;
    pix("cursor_off", 20, 20, 12'h111, 12'h00f);
    cursor_en = 1'b1;
    pix("cursor_reon", 20, 20, 12'h111, 12'hfff);
    cursor_idx = 4'd9;
    vs_pulse();
    pix("cursor_bad", 20, 20, 12'h111, 12'h00f);
    cursor_en = 1'b0;

    // async reset mid-line with populated board and a write in flight
    hsync_in = 1'b1;
    pix("pre_reset", 20, 20, 12'habc, 12'h00f);
    #3;
    rst_n  = 1'b0;
    wr_en  = 1'b1; wr_idx = 4'd4; wr_val = 2'd2;
    #1;
    chk("arst_rgb", 32'(rgb_out), 32'h0);
    chk("arst_hcount", 32'(hcount_out), 32'd0);
    chk("arst_hsync", 32'(hsync_out), 32'd0);
    tick();
    wr_en = 1'b0;
    rst_n = 1'b1;
    hsync_in = 1'b0;
    vs_pulse();
    pix("post_c0", 20, 20, 12'habc, 12'habc);
    pix("post_c4", 500, 400, 12'habc, 12'habc);
    chk("post_hcount", 32'(hcount_out), 32'd500);
    chk("post_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_square_grid.md
DRAW_SQUARE_GRID -- requirements
Module: draw_square_grid

Interface
REQ-001 The block SHALL have parameter ROWS, default 3, meaning board rows.
REQ-002 The block SHALL have parameter COLS, default 3, meaning board columns; N = ROWS*COLS cells, IW = clog2(N) index bits.
REQ-003 The block SHALL have parameters X0 and Y0, default 0 and 0, meaning the top-left pixel of cell 0.
REQ-004 The block SHALL have parameters CELL_W and CELL_H, default 341 and 256, meaning the cell size in pixels.
REQ-005 The block SHALL have parameter BLINK_FRAMES, default 30, meaning frames per cursor blink half-period.
REQ-006 The block SHALL have parameter CURSOR_COLOR, default 12'hfff, meaning the cursor highlight colour.
REQ-007 The block SHALL have the following ports:
- pclk  in  1  pixel clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hcount_in/vcount_in  in  11  pixel position.
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1  timing.
- rgb_in  in  12  upstream pixel.
- start_en, choice_en  in  1  game phase; drawing is enabled when start_en=1 and choice_en=0.
- wr_en  in  1  mark write strobe.
- wr_idx  in  IW  target cell, row-major, 0 = top-left.
- wr_val  in  2  0=empty, 1=player0, 2=player1, 3=reserved.
- clr  in  1  clear all marks.
- cursor_en  in  1  show cursor.
- cursor_idx  in  IW  cursor cell.
- hcount_out/vcount_out  out  11  delayed position.
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1  delayed timing.
- rgb_out  out  12  composed pixel.
- busy  out  1  pending board differs from displayed board.

Function
REQ-008 Timing/position outputs SHALL equal their inputs delayed exactly 2 pclk cycles; rgb_out SHALL be aligned with them.
REQ-009 Stage 1 SHALL register the cell hit and index: hit when X0 <= hcount_in <= X0+COLS*CELL_W-1 and Y0 <= vcount_in <= Y0+ROWS*CELL_H-1.
REQ-010 In stage 1, col = (hcount_in-X0)/CELL_W and row = (vcount_in-Y0)/CELL_H, computed by comparison chains (no dividers); idx = row*COLS+col.
REQ-011 Stage 2 SHALL select rgb_out by the following priority:
- not enabled or not hit: rgb_in delayed 2.
- cursor_en and idx==cursor_idx_latched and blink phase=1: CURSOR_COLOR.
- displayed mark 1: 12'h00f (BLUE).
- displayed mark 2: 12'hff0 (YELLOW).
- else: rgb_in delayed 2.
REQ-012 The pending board SHALL be N x 2-bit registers updated in the cycle after the write:
- clr=1: all cells 0.
- else wr_en=1 and wr_idx<N and wr_val!=3: cell[wr_idx] <= wr_val.
- otherwise ignored.
REQ-013 clr SHALL take priority over wr_en in the same cycle.
REQ-014 Writes with wr_idx>=N or wr_val==3 SHALL be dropped without affecting any state.
REQ-015 The displayed board SHALL copy the pending board only on the cycle a rising edge of vsync_in is detected (vsync_in=1, previous sample 0).
REQ-016 A write in the same cycle as the vsync edge SHALL NOT appear until the next vsync edge; the board SHALL never change mid-frame.
REQ-017 cursor_idx SHALL be latched on the same vsync edge.
REQ-018 A cursor_idx>=N SHALL show no cursor.
REQ-019 busy SHALL be registered and equal (pending != displayed).
REQ-020 The frame counter SHALL be clog2(BLINK_FRAMES) bits, increment on each vsync rising edge, and on reaching BLINK_FRAMES-1 wrap to 0 and toggle the blink phase.
REQ-021 When cursor_en=0, the frame counter SHALL reset to 0 and the blink phase to 1, so the cursor is visible immediately when re-enabled.
REQ-022 No arithmetic overflow SHALL be allowed: comparisons SHALL be 12-bit, and parameters SHALL satisfy X0+COLS*CELL_W <= 2047.

Reset
REQ-023 When rst_n=0, all outputs, pipeline registers, both boards, the cursor latch, and the frame counter SHALL be 0 asynchronously.
REQ-024 On reset, the blink phase SHALL be 1 and the previous-vsync sample SHALL be 0.
REQ-025 Reset deassertion SHALL be synchronous to pclk; on the first active cycle the block SHALL pass rgb_in through.
REQ-026 Reset mid-frame SHALL discard the pending board and any write in flight.

Verification
REQ-027 Passthrough: start_en=0, rgb_in=12'h123 at (700,600) -> rgb_out=12'h123 two cycles later, with hcount_out=700 and vcount_out=600.
REQ-028 Mark: wr_en, wr_idx=8, wr_val=1, then a vsync edge -> pixels (685..1022, 512..767) = 12'h00f; (681,600) = rgb_in; busy goes 1 then 0.
REQ-029 Tearing: write wr_idx=4, wr_val=2 at vcount=400 -> the current frame is unchanged; the next frame shows (500,400) = 12'hff0.
REQ-030 Priority and illegal writes: clr and wr_en in the same cycle -> all cells empty; wr_idx=9 or wr_val=3 -> no change and busy=0.
REQ-031 Blink: cursor_en=1, cursor_idx=0, BLINK_FRAMES=2 -> cell 0 shows CURSOR_COLOR in frames 0-1, its mark/rgb_in in frames 2-3, and repeats.
REQ-032 Async reset: drop rst_n mid-line with the board populated -> outputs 0 with no clock edge; after release, cells are empty.
